// File: rtl/boot_pkg.sv
// Shared types and frame constants for the instruction-memory boot loader.
package boot_pkg;

  typedef enum logic [2:0] {
    HDR0      = 3'd0,
    HDR1      = 3'd1,
    DATA      = 3'd2,
    CSUM      = 3'd3,
    RESET_REL = 3'd4,
    DONE      = 3'd5,
    ERR       = 3'd6
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int CNT_BYTES      = 2;

endpackage

// File: rtl/byte_to_word_packer.sv
// Big-endian 4-byte assembly register; strobes the finished word one cycle
// after its last byte is accepted.
module byte_to_word_packer
  import boot_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        last_byte_o,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic        word_valid_q, word_valid_d;

  assign last_byte_o = (idx_q == 2'(BYTES_PER_WORD - 1));

  always_comb begin
    idx_d        = idx_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    if (byte_valid_i) begin
      word_d       = {word_q[23:0], byte_i};
      idx_d        = idx_q + 2'd1;
      word_valid_d = last_byte_o;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q        <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign word_valid_o = word_valid_q;
  assign word_o       = word_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Byte-serial program loader: writes a framed image into instruction memory
// and holds the core in reset until the image checksum matches.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_WORD = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_err
);

  localparam int          MAX_WORDS = 1 << ADDR_W;
  localparam logic [31:0] N_LIMIT   = 32'(MAX_WORDS - BASE_WORD);

  state_e             state_q, state_d;
  logic [7:0]         cnt_hi_q, cnt_hi_d;
  logic [ADDR_W:0]    n_q, n_d;
  logic [ADDR_W:0]    cnt_q, cnt_d;
  logic [7:0]         csum_q, csum_d;
  logic               rx_ready_q;

  logic                   xfer;
  logic [8*CNT_BYTES-1:0] n_w;
  logic                   last_byte;
  logic                   word_valid;
  logic [31:0]            word;

  assign xfer = rx_valid && rx_ready_q;
  assign n_w  = {cnt_hi_q, rx_data};

  byte_to_word_packer u_packer (
    .clock        (clock),
    .reset        (reset),
    .byte_valid_i (xfer && (state_q == DATA)),
    .byte_i       (rx_data),
    .last_byte_o  (last_byte),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_comb begin
    state_d  = state_q;
    cnt_hi_d = cnt_hi_q;
    n_d      = n_q;
    csum_d   = csum_q;
    cnt_d    = word_valid ? cnt_q + 1'b1 : cnt_q;
    case (state_q)
      HDR0: begin
        if (xfer) begin
          cnt_hi_d = rx_data;
          state_d  = HDR1;
        end
      end
      HDR1: begin
        if (xfer) begin
          if (n_w == '0) begin
            state_d = CSUM;
          end else if ({16'd0, n_w} > N_LIMIT) begin
            state_d = ERR;
          end else begin
            n_d     = (ADDR_W + 1)'(n_w);
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          csum_d = csum_q ^ rx_data;
          // Leave on the last byte so the checksum byte is never taken as data;
          // the final write strobe then lands in the first CSUM cycle.
          if (last_byte && (cnt_q == n_q - 1'b1)) state_d = CSUM;
        end
      end
      CSUM: begin
        if (xfer) state_d = (rx_data == csum_q) ? RESET_REL : ERR;
      end
      RESET_REL: state_d = DONE;
      DONE:      state_d = DONE;
      ERR:       state_d = ERR;
      default:   state_d = ERR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= HDR0;
      cnt_hi_q   <= '0;
      n_q        <= '0;
      cnt_q      <= '0;
      csum_q     <= '0;
      rx_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_hi_q   <= cnt_hi_d;
      n_q        <= n_d;
      cnt_q      <= cnt_d;
      csum_q     <= csum_d;
      rx_ready_q <= (state_d inside {HDR0, HDR1, DATA, CSUM});
    end
  end

  assign rx_ready  = rx_ready_q;
  assign im_we     = word_valid;
  assign im_wdata  = word;
  assign im_addr   = ADDR_W'(BASE_WORD) + cnt_q[ADDR_W-1:0];
  assign cpu_reset = (state_q != DONE);
  assign load_done = (state_q == RESET_REL) || (state_q == DONE);
  assign load_err  = (state_q == ERR);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: frame-level model plus a per-cycle
// write checker and a tiny MIPS subset interpreter over the loaded image.
module tb_imem_boot_loader;

  localparam int AW = 10;
  typedef logic [7:0]  bq_t[$];
  typedef logic [31:0] wq_t[$];

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_ready, im_we, cpu_reset, load_done, load_err;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;

  imem_boot_loader #(.ADDR_W(AW), .BASE_WORD(0)) dut (
    .clock     (clock),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .im_we     (im_we),
    .im_addr   (im_addr),
    .im_wdata  (im_wdata),
    .cpu_reset (cpu_reset),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_mis = 0;
  int wr_cnt = 0;
  logic [AW-1:0] exp_addr_q[$];
  logic [31:0]   exp_data_q[$];
  logic [31:0]   rom [0:(1<<AW)-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Per-cycle checker: every write must be the next one the model predicted.
  always @(negedge clock) begin
    if (!reset) begin
      if (im_we) begin
        wr_cnt++;
        rom[im_addr] = im_wdata;
        if (exp_addr_q.size() == 0) begin
          check("unexpected_we", 32'd1, 32'd0);
        end else begin
          check("we_addr", 32'(im_addr), 32'(exp_addr_q.pop_front()));
          check("we_data", im_wdata, exp_data_q.pop_front());
        end
      end
      if (!cpu_reset) check("writes_before_release", 32'(exp_addr_q.size()), 32'd0);
      check("done_err_exclusive", 32'(load_done & load_err), 32'd0);
    end
  end

  function automatic bq_t mk_frame(input wq_t w, input bit bad_csum);
    bq_t f;
    logic [7:0] x = 8'h00;
    f.push_back(8'(w.size() >> 8));
    f.push_back(8'(w.size()));
    foreach (w[i]) begin
      for (int b = 3; b >= 0; b--) begin
        f.push_back(w[i][8*b +: 8]);
        x ^= w[i][8*b +: 8];
      end
    end
    f.push_back(bad_csum ? 8'h00 : x);
    return f;
  endfunction

  // Frame-level model: queues the writes the frame implies and predicts the outcome.
  task automatic model_frame(input bq_t f, output bit exp_done);
    int n;
    logic [7:0] x;
    logic [31:0] wd;
    n = {f[0], f[1]};
    exp_done = 1'b0;
    if (n > (1 << AW)) return;
    x = 8'h00;
    for (int k = 0; k < n; k++) begin
      wd = {f[2+4*k], f[3+4*k], f[4+4*k], f[5+4*k]};
      x ^= f[2+4*k] ^ f[3+4*k] ^ f[4+4*k] ^ f[5+4*k];
      exp_addr_q.push_back(AW'(k));
      exp_data_q.push_back(wd);
    end
    exp_done = (f.size() > 2 + 4*n) && (f[2+4*n] == x);
  endtask

  task automatic send_frame(input bq_t f, input int gapmax);
    int t;
    int g;
    foreach (f[i]) begin
      @(negedge clock);
      if (gapmax > 0) begin
        g = $urandom_range(0, gapmax);
        rx_valid = 1'b0;
        repeat (g) @(negedge clock);
      end
      rx_valid = 1'b1;
      rx_data  = f[i];
      t = 0;
      while (!rx_ready && t < 50) begin
        @(negedge clock);
        t++;
      end
      if (t >= 50) begin
        check("rx_ready_timeout", 32'd0, 32'd1);
        rx_valid = 1'b0;
        return;
      end
      @(posedge clock);
    end
  endtask

  task automatic wait_outcome(input bit exp_done, output int lat);
    @(negedge clock);
    rx_valid = 1'b0;
    lat = 0;
    while (!load_done && !load_err && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    check("outcome_done", 32'(load_done), 32'(exp_done));
    check("outcome_err", 32'(load_err), 32'(!exp_done));
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    rx_valid = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    repeat (2) @(negedge clock);
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_im_we", 32'(im_we), 32'd0);
    check("rst_im_addr", 32'(im_addr), 32'd0);
    check("rst_im_wdata", im_wdata, 32'd0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);
    reset = 1'b0;
    wr_cnt = 0;
    @(negedge clock);
    check("rx_ready_after_rst", 32'(rx_ready), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t f;
    wq_t w;
    bit ed;
    int lat;
    logic [31:0] r [32];
    logic [31:0] ins;

    // Nominal load, hand-written frame: XOR of the 8 payload bytes is 0x0E.
    do_reset();
    f = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0E};
    model_frame(f, ed);
    check("model_nominal_done", 32'(ed), 32'd1);
    send_frame(f, 0);
    wait_outcome(1'b1, lat);
    check("nom_reset_rel_lat", 32'(lat), 32'd0);
    check("nom_cpu_reset_held", 32'(cpu_reset), 32'd1);
    @(negedge clock);
    check("nom_cpu_reset_fall", 32'(cpu_reset), 32'd0);
    check("nom_load_done", 32'(load_done), 32'd1);
    check("nom_rx_ready_off", 32'(rx_ready), 32'd0);
    check("nom_wr_cnt", 32'(wr_cnt), 32'd2);
    check("nom_rom0", rom[0], 32'h20080005);
    check("nom_rom1", rom[1], 32'h2009000A);

    // Checksum error: both writes still happen, then terminal error.
    do_reset();
    w = '{32'h20080005, 32'h2009000A};
    f = mk_frame(w, 1'b1);
    model_frame(f, ed);
    send_frame(f, 0);
    wait_outcome(ed, lat);
    repeat (100) @(negedge clock);
    check("cs_load_err", 32'(load_err), 32'd1);
    check("cs_cpu_reset", 32'(cpu_reset), 32'd1);
    check("cs_rx_ready", 32'(rx_ready), 32'd0);
    check("cs_wr_cnt", 32'(wr_cnt), 32'd2);

    // Empty image.
    do_reset();
    f = '{8'h00, 8'h00, 8'h00};
    model_frame(f, ed);
    send_frame(f, 0);
    wait_outcome(1'b1, lat);
    repeat (3) @(negedge clock);
    check("empty_cpu_reset", 32'(cpu_reset), 32'd0);
    check("empty_wr_cnt", 32'(wr_cnt), 32'd0);

    // Oversize header: 0x0401 words cannot fit in 1024.
    do_reset();
    f = '{8'h04, 8'h01};
    model_frame(f, ed);
    send_frame(f, 0);
    wait_outcome(1'b0, lat);
    check("over_err_lat", 32'(lat), 32'd0);
    repeat (5) @(negedge clock);
    check("over_rx_ready", 32'(rx_ready), 32'd0);
    check("over_wr_cnt", 32'(wr_cnt), 32'd0);

    // Gapped stream of the nominal frame.
    do_reset();
    w = '{32'h20080005, 32'h2009000A};
    f = mk_frame(w, 1'b0);
    model_frame(f, ed);
    send_frame(f, 5);
    wait_outcome(ed, lat);
    @(negedge clock);
    check("gap_cpu_reset", 32'(cpu_reset), 32'd0);
    check("gap_wr_cnt", 32'(wr_cnt), 32'd2);

    // Mid-frame reset after 3 payload bytes, then a full frame.
    do_reset();
    f = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE};
    send_frame(f, 0);
    do_reset();
    check("abort_wr_cnt", 32'(wr_cnt), 32'd0);
    w = '{32'h20080005, 32'h2009000A};
    f = mk_frame(w, 1'b0);
    model_frame(f, ed);
    send_frame(f, 0);
    wait_outcome(ed, lat);
    check("restart_wr_cnt", 32'(wr_cnt), 32'd2);
    check("restart_rom0", rom[0], 32'h20080005);

    // Core boot: addi $t0,5; addi $t1,10; add $t2,$t0,$t1; nop.
    do_reset();
    w = '{32'h20080005, 32'h2009000A, 32'h01095020, 32'h00000000};
    f = mk_frame(w, 1'b0);
    model_frame(f, ed);
    send_frame(f, 0);
    wait_outcome(ed, lat);
    @(negedge clock);
    check("boot_cpu_reset", 32'(cpu_reset), 32'd0);
    check("boot_first_fetch", rom[0], 32'h20080005);
    foreach (r[i]) r[i] = 32'd0;
    for (int pc = 0; pc < 4; pc++) begin
      ins = rom[pc];
      if (ins[31:26] == 6'h08)
        r[ins[20:16]] = r[ins[25:21]] + {{16{ins[15]}}, ins[15:0]};
      else if (ins[31:26] == 6'h00 && ins[5:0] == 6'h20)
        r[ins[15:11]] = r[ins[25:21]] + r[ins[20:16]];
      r[0] = 32'd0;
    end
    check("boot_t0", r[8], 32'h00000005);
    check("boot_t2", r[10], 32'h0000000F);

    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
